// File: rtl/seg8_pkg.sv
// Shared definitions for the multiplexed 8-segment display bus.
// Holds the hex segment table, the word layout and small helpers.
// Both the display driver's encoder and the capture decoder use it.
package seg8_pkg;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned DATA_W   = 20;
  localparam int unsigned SEG_W    = 7;

  // Segment patterns for hex 0..F; bit 0 = segment a, bit 6 = segment g.
  // Entry 0 is the rightmost element.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Word layout: digit k nibble -> data[4k+3:4k], dot -> data[16+k].
  typedef struct packed {
    logic [DIGITS-1:0]                dots;
    logic [DIGITS-1:0][NIBBLE_W-1:0]  nibbles;
  } capture_word_t;

  // Encoder side of the table, used by the display driver.
  function automatic logic [SEG_W-1:0] seg_encode(input logic [NIBBLE_W-1:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

  // Index of the set bit of a one-hot drain vector.
  function automatic logic [1:0] onehot_index(input logic [DIGITS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg8_capture_if.sv
// Display-bus interface for seg8_capture.
// drains/leds: scanned display bus (driven by the display side).
// data/data_valid/frame_err/stale: reassembled frame results.
interface seg8_capture_if;

  logic [seg8_pkg::DIGITS-1:0] drains;
  logic [7:0]                  leds;
  logic [seg8_pkg::DATA_W-1:0] data;
  logic                        data_valid;
  logic                        frame_err;
  logic                        stale;

  // Display driver / stimulus side.
  modport master (
    output drains, leds,
    input  data, data_valid, frame_err, stale
  );

  // Capture block side.
  modport slave (
    input  drains, leds,
    output data, data_valid, frame_err, stale
  );

endinterface

// File: rtl/seg8_pattern_decode.sv
// Combinational inverse of the driver's digit encoder.
// segs  : segment lines a..g.
// valid : 1 when segs matches one of the 16 hex patterns.
// nibble: decoded hex value, 0 when not valid.
module seg8_pattern_decode
  import seg8_pkg::*;
(
  input  logic [SEG_W-1:0]    segs,
  output logic                valid,
  output logic [NIBBLE_W-1:0] nibble
);

  // Searching the shared table keeps this an exact inverse of seg_encode.
  always_comb begin
    valid  = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (segs == SEG_TABLE[i]) begin
        valid  = 1'b1;
        nibble = NIBBLE_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg8_capture.sv
// Receiver for a 4-digit multiplexed 8-segment display bus.
// Synchronizes the bus, waits for each digit dwell to settle, decodes it
// and reassembles the 20-bit word, flagging undecodable digits and a stale bus.
// clk, rst : clock and asynchronous active-high reset.
// bus      : drains/leds in; data, data_valid, frame_err, stale out.
module seg8_capture
  import seg8_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic          clk,
  input  logic          rst,
  seg8_capture_if.slave bus
);

  localparam int unsigned BUS_W = DIGITS + 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {SETTLE, HOLD} state_t;

  logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q;
  logic [BUS_W-1:0]                  s;
  logic [BUS_W-1:0]                  s_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept_c;

  logic [DIGITS-1:0] drains_s;
  logic [1:0]        digit_c;
  logic              dec_valid;
  logic [NIBBLE_W-1:0] dec_nibble;

  capture_word_t     frame_q, frame_next;
  logic [DIGITS-1:0] seen_q, seen_next;
  logic [DIGITS-1:0] err_q, err_next;
  logic [TMO_W-1:0]  tmo_q;

  logic [DATA_W-1:0] data_q;
  logic              data_valid_q;
  logic              frame_err_q;
  logic              stale_q;

  // Input synchronizer plus one-sample history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_q    <= '0;
    end else begin
      sync_q[0] <= {bus.drains, bus.leds};
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      s_q <= s;
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign drains_s = s[BUS_W-1:8];
  assign digit_c  = onehot_index(drains_s);

  seg8_pattern_decode u_decode (
    .segs   (s[SEG_W-1:0]),
    .valid  (dec_valid),
    .nibble (dec_nibble)
  );

  // Stability FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stability FSM: one accept per stable dwell; blank/non-one-hot dwells are skipped.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      SETTLE: begin
        if (s != s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d  = HOLD;
          cnt_d    = '0;
          accept_c = $onehot(drains_s);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (s != s_q) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame contents as they would be after accepting the current digit.
  always_comb begin
    frame_next                   = frame_q;
    frame_next.nibbles[digit_c]  = dec_valid ? dec_nibble : '0;
    frame_next.dots[digit_c]     = s[7];
    seen_next                    = seen_q | (DIGITS'(1) << digit_c);
    err_next                     = err_q;
    err_next[digit_c]            = ~dec_valid;
  end

  // Frame assembly, completion and stale-bus timeout; an accept beats a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q      <= '0;
      seen_q       <= '0;
      err_q        <= '0;
      tmo_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      stale_q      <= 1'b1;
    end else begin
      data_valid_q <= 1'b0;
      if (accept_c) begin
        frame_q <= frame_next;
        tmo_q   <= '0;
        stale_q <= 1'b0;
        if (seen_next == {DIGITS{1'b1}}) begin
          data_q       <= frame_next;
          frame_err_q  <= |err_next;
          data_valid_q <= 1'b1;
          seen_q       <= '0;
          err_q        <= '0;
        end else begin
          seen_q <= seen_next;
          err_q  <= err_next;
        end
      end else if (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_q   <= TMO_W'(TIMEOUT_CYCLES);
        seen_q  <= '0;
        err_q   <= '0;
        stale_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.stale      = stale_q;

endmodule

// File: tb/tb_seg8_capture.sv
// Testbench for seg8_capture: drives digit dwells on the display bus and
// scoreboards every data_valid against a frame-level reference model.
module tb_seg8_capture;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 4;
  localparam int unsigned TMO    = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg8_capture_if bus ();

  seg8_capture #(
    .SYNC_STAGES    (SYNC),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_exp   = 0;

  // Reference model: per-digit slots and a queue of expected {frame_err, data}.
  logic [3:0] m_nib  [4];
  logic       m_dot  [4];
  logic       m_seen [4];
  logic       m_err  [4];
  logic [20:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_seen[i] = 1'b0;
      m_err[i]  = 1'b0;
    end
  endtask

  task automatic model_accept(input int k, input logic [6:0] pat, input logic dot);
    logic found;
    logic [3:0] val;
    logic all;
    logic [19:0] word;
    logic ferr;
    found = 1'b0;
    val   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg_tab[i] == pat) begin
        found = 1'b1;
        val   = 4'(i);
      end
    end
    m_nib[k]  = val;
    m_dot[k]  = dot;
    m_err[k]  = !found;
    m_seen[k] = 1'b1;
    all = 1'b1;
    for (int i = 0; i < 4; i++) all = all & m_seen[i];
    if (all) begin
      word = '0;
      ferr = 1'b0;
      for (int i = 0; i < 4; i++) begin
        word[4*i +: 4] = m_nib[i];
        word[16 + i]   = m_dot[i];
        ferr           = ferr | m_err[i];
      end
      exp_q.push_back({ferr, word});
      n_exp++;
      model_clear();
    end
  endtask

  task automatic blank(input int n);
    @(posedge clk); #1;
    bus.drains = 4'b0000;
    bus.leds   = 8'($urandom);
    repeat (n) @(posedge clk);
  endtask

  // One digit dwell preceded by a short blank; acc=0 means the dwell is too short to count.
  task automatic show(input int k, input logic [6:0] pat, input logic dot, input int dwell, input bit acc);
    blank(2);
    @(posedge clk); #1;
    bus.drains = 4'(1 << k);
    bus.leds   = {dot, pat};
    if (acc) model_accept(k, pat, dot);
    repeat (dwell) @(posedge clk);
  endtask

  task automatic show_word(input logic [19:0] w, input int dwell);
    for (int k = 0; k < 4; k++) show(k, seg_tab[w[4*k +: 4]], w[16+k], dwell, 1'b1);
  endtask

  // Monitor: every data_valid pulse must match the next expected frame.
  always @(negedge clk) begin
    if (!rst && bus.data_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data %0h with no frame expected", bus.data);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check("frame_data", 32'(bus.data), 32'(e[19:0]));
        check("frame_err", 32'(bus.frame_err), 32'(e[20]));
      end
    end
  end

  initial begin
    int order [4];
    bus.drains = 4'b0000;
    bus.leds   = 8'h00;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      m_nib[i] = 4'h0;
      m_dot[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(bus.data), 32'h0);
    check("rst_valid", 32'(bus.data_valid), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_stale", 32'(bus.stale), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Loopback-style scan, two rotations at 64 clocks per digit.
    repeat (2) show_word(20'hA_1234, 64);
    blank(10);
    check("stale_after_frames", 32'(bus.stale), 32'h0);

    // Undecodable digit 2 inside 5678, then a clean frame.
    show(0, seg_tab[8], 1'b0, 12, 1'b1);
    show(1, seg_tab[7], 1'b0, 12, 1'b1);
    show(2, 7'h00,      1'b0, 12, 1'b1);
    show(3, seg_tab[5], 1'b0, 12, 1'b1);
    show_word(20'h3_9ABC, 12);

    // Glitch and too-short dwell are ignored; a 500-clock dwell accepts once.
    blank(10);
    @(posedge clk); #1;
    bus.drains = 4'b0011;
    bus.leds   = {1'b0, seg_tab[1]};
    blank(10);
    show(3, seg_tab[4], 1'b0, STABLE - 1, 1'b0);
    blank(10);
    for (int k = 0; k < 3; k++) show(k, seg_tab[k + 6], 1'b1, 12, 1'b1);
    show(3, seg_tab[2], 1'b0, 500, 1'b1);
    for (int k = 0; k < 3; k++) show(k, seg_tab[k + 1], 1'b0, 12, 1'b1);
    show(3, seg_tab[15], 1'b1, 12, 1'b1);

    // Order 3,1,0,1(new),2: latest digit-1 value wins.
    show(3, seg_tab[13], 1'b0, 12, 1'b1);
    show(1, seg_tab[2],  1'b1, 12, 1'b1);
    show(0, seg_tab[0],  1'b0, 12, 1'b1);
    show(1, seg_tab[9],  1'b0, 12, 1'b1);
    show(2, seg_tab[11], 1'b1, 12, 1'b1);

    // Random frames: shuffled order, random values, occasional bad pattern or repeat.
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 4; i++) order[i] = i;
      for (int i = 3; i > 0; i--) begin
        int j;
        int t;
        j = int'($urandom_range(i, 0));
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 4; i++) begin
        logic [6:0] pat;
        if ($urandom_range(5, 0) == 0) pat = 7'($urandom);
        else pat = seg_tab[$urandom_range(15, 0)];
        if (i == 2 && $urandom_range(2, 0) == 0)
          show(order[0], seg_tab[$urandom_range(15, 0)], 1'($urandom), 12, 1'b1);
        show(order[i], pat, 1'($urandom), int'($urandom_range(20, 10)), 1'b1);
      end
    end

    // Timeout after two digits drops the partial frame and raises stale.
    show(0, seg_tab[1], 1'b0, 12, 1'b1);
    show(1, seg_tab[2], 1'b0, 12, 1'b1);
    blank(TMO - 100);
    check("stale_before_timeout", 32'(bus.stale), 32'h0);
    blank(200);
    model_clear();
    check("stale_after_timeout", 32'(bus.stale), 32'h1);
    show(2, seg_tab[3], 1'b0, 12, 1'b1);
    check("stale_cleared", 32'(bus.stale), 32'h0);
    show(3, seg_tab[4], 1'b0, 12, 1'b1);
    show(0, seg_tab[5], 1'b1, 12, 1'b1);
    show(1, seg_tab[6], 1'b0, 12, 1'b1);

    // Reset after three digits; only a fourth digit afterwards must not complete a frame.
    show(0, seg_tab[7], 1'b0, 12, 1'b1);
    show(1, seg_tab[8], 1'b0, 12, 1'b1);
    show(2, seg_tab[9], 1'b0, 12, 1'b1);
    @(posedge clk); #1;
    bus.drains = 4'b0000;
    rst = 1'b1;
    model_clear();
    #1;
    check("midrst_data", 32'(bus.data), 32'h0);
    check("midrst_valid", 32'(bus.data_valid), 32'h0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
    check("midrst_stale", 32'(bus.stale), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    show(3, seg_tab[10], 1'b0, 12, 1'b1);
    blank(30);
    check("post_rst_stale", 32'(bus.stale), 32'h0);
    check("pending_frames", 32'(exp_q.size()), 32'h0);
    check("valid_count", 32'(n_valid), 32'(n_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
